// File: rtl/pipe_cp_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cp_pkg
//  Description : Shared decode constants, control-word layout and the
//                opcode-class decoder used by the control-path generator.
//  Revision    : 1.0  initial release
// ============================================================================
package cp_pkg;

    // Instruction classes taken from OPCODE[9:7]
    typedef enum logic [2:0] {
        CLS_ALU_REG = 3'b000,
        CLS_ALU_IMM = 3'b001,
        CLS_LOGIC   = 3'b010,
        CLS_LOAD    = 3'b011,
        CLS_STORE   = 3'b100,
        CLS_BCOND   = 3'b101,
        CLS_BX      = 3'b110,
        CLS_ILLEGAL = 3'b111
    } op_class_e;

    // ARM-style condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // One-hot immediate selects
    localparam logic [3:0] IMMSEL_REG = 4'b0001;
    localparam logic [3:0] IMMSEL_IMM = 4'b0010;
    localparam logic [3:0] IMMSEL_MEM = 4'b0100;
    localparam logic [3:0] IMMSEL_BR  = 4'b1000;

    localparam logic [3:0] ALUOP_ADD  = 4'b0100;

    // Flag write masks and bit positions (N,Z,C,V = 3..0)
    localparam logic [3:0] NZCV_ALL   = 4'b1111;
    localparam logic [3:0] NZCV_NZ    = 4'b1100;
    localparam int         FLAG_N     = 3;
    localparam int         FLAG_Z     = 2;
    localparam int         FLAG_C     = 1;
    localparam int         FLAG_V     = 0;

    // Control word carried down the pipeline alongside each valid bit
    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc;
        logic       regwrite;
        logic       memrw;
        logic       memtoreg;
        logic [3:0] nzcvwrite;
        logic [3:0] immsel;
        logic       bsel;
        logic       c_branch;
        logic       r_branch;
        logic [3:0] cond;
        logic       illegal;
    } ctrl_t;

    // Class decode; unlisted fields stay zero
    function automatic ctrl_t cp_decode(input op_class_e cls,
                                        input logic      s_bit,
                                        input logic [3:0] low);
        ctrl_t c;
        c = '0;
        case (cls)
            CLS_ALU_REG: begin
                c.aluop     = low;
                c.regwrite  = 1'b1;
                c.immsel    = IMMSEL_REG;
                c.nzcvwrite = s_bit ? NZCV_ALL : 4'b0000;
            end
            CLS_ALU_IMM: begin
                c.aluop     = low;
                c.alusrc    = 1'b1;
                c.regwrite  = 1'b1;
                c.immsel    = IMMSEL_IMM;
                c.nzcvwrite = s_bit ? NZCV_ALL : 4'b0000;
            end
            CLS_LOGIC: begin
                c.aluop     = low;
                c.regwrite  = 1'b1;
                c.immsel    = IMMSEL_REG;
                c.nzcvwrite = s_bit ? NZCV_NZ : 4'b0000;
            end
            CLS_LOAD: begin
                c.aluop     = ALUOP_ADD;
                c.alusrc    = 1'b1;
                c.memtoreg  = 1'b1;
                c.regwrite  = 1'b1;
                c.immsel    = IMMSEL_MEM;
            end
            CLS_STORE: begin
                c.aluop     = ALUOP_ADD;
                c.alusrc    = 1'b1;
                c.memrw     = 1'b1;
                c.immsel    = IMMSEL_MEM;
            end
            CLS_BCOND: begin
                c.c_branch  = 1'b1;
                c.bsel      = 1'b1;
                c.immsel    = IMMSEL_BR;
                c.cond      = low;
            end
            CLS_BX: begin
                c.r_branch  = 1'b1;
                c.cond      = COND_AL;
            end
            default: begin
                c.illegal   = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_cp_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_cp_gen_if
//  Description : Opcode input / decoded control output bundle of the
//                control-path generator. The master drives opcodes and
//                pipeline controls, the slave (the generator) drives controls.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_cp_gen_if #(
    parameter int OPW = 10
);
    logic           VALID_IN;
    logic [OPW-1:0] OPCODE;
    logic           STALL;
    logic           FLUSH;
    logic [3:0]     NZCV_IN;
    logic           READY;
    logic           VALID_OUT;
    logic [3:0]     ALUOP;
    logic           ALUSRC;
    logic           REGWRITE;
    logic           MEMRW;
    logic           MEMTOREG;
    logic [3:0]     NZCVWRITE;
    logic [3:0]     IMMSEL;
    logic           BSEL;
    logic           C_BRANCH;
    logic           R_BRANCH;
    logic [3:0]     COND;
    logic           TAKEN;
    logic           FLUSH_OUT;
    logic           ILLEGAL;

    modport master (
        output VALID_IN, OPCODE, STALL, FLUSH, NZCV_IN,
        input  READY, VALID_OUT, ALUOP, ALUSRC, REGWRITE, MEMRW, MEMTOREG,
               NZCVWRITE, IMMSEL, BSEL, C_BRANCH, R_BRANCH, COND, TAKEN,
               FLUSH_OUT, ILLEGAL
    );

    modport slave (
        input  VALID_IN, OPCODE, STALL, FLUSH, NZCV_IN,
        output READY, VALID_OUT, ALUOP, ALUSRC, REGWRITE, MEMRW, MEMTOREG,
               NZCVWRITE, IMMSEL, BSEL, C_BRANCH, R_BRANCH, COND, TAKEN,
               FLUSH_OUT, ILLEGAL
    );
endinterface
`default_nettype wire

// File: rtl/cp_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : cp_cond_eval
//  Description : Combinational ARM-style condition check of a 4-bit condition
//                code against the N,Z,C,V flag register.
//  Revision    : 1.0  initial release
// ============================================================================
module cp_cond_eval
    import cp_pkg::*;
(
    input  wire logic [3:0] i_cond,
    input  wire logic [3:0] i_flags,
    output logic            o_pass
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    // Evaluate the condition; 1111 is the never-taken encoding
    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = ~w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = ~w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = ~w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = ~w_v;
            COND_HI: o_pass = w_c & ~w_z;
            COND_LS: o_pass = ~w_c | w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = ~w_z & (w_n == w_v);
            COND_LE: o_pass = w_z | (w_n != w_v);
            COND_AL: o_pass = 1'b1;
            COND_NV: o_pass = 1'b0;
            default: o_pass = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pipe_cp_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_cp_gen
//  Description : Pipelined control-path generator. Opcodes are decoded in
//                stage 1 and shifted through STAGES registers; the output
//                stage drives the control bundle, updates the NZCV flag
//                register and resolves branches, squashing younger work on a
//                taken branch.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_cp_gen
    import cp_pkg::*;
#(
    parameter int OPW    = 10,   // opcode width, >= 10
    parameter int STAGES = 3     // acceptance-to-output depth, 1..4
) (
    input  wire logic     CLK,
    input  wire logic     RST,
    pipe_cp_gen_if.slave  bus
);

    logic       w_upper_nz;
    op_class_e  w_cls;
    ctrl_t      w_dec;
    logic       w_accept;
    logic       w_kill;
    logic       w_out_valid;
    ctrl_t      w_out;
    logic       w_pass;
    logic       w_taken;
    logic       w_flush_out;
    logic       w_unused_bits;

    logic       r_valid [STAGES];
    ctrl_t      r_ctrl  [STAGES];
    logic [3:0] r_flags;

    // Any set bit above the fixed 10-bit layout marks the opcode undefined
    generate
        if (OPW > 10) begin : g_wide_opcode
            assign w_upper_nz = |bus.OPCODE[OPW-1:10];
        end else begin : g_narrow_opcode
            assign w_upper_nz = 1'b0;
        end
    endgenerate

    assign w_cls    = w_upper_nz ? CLS_ILLEGAL : op_class_e'(bus.OPCODE[9:7]);
    assign w_dec    = cp_decode(w_cls, bus.OPCODE[4], bus.OPCODE[3:0]);

    // Opcode bits [6:5] carry no control meaning
    assign w_unused_bits = &{1'b0, bus.OPCODE[6:5]};

    assign bus.READY = ~bus.STALL;
    assign w_accept  = bus.VALID_IN & ~bus.STALL;

    // A taken branch at the output squashes every younger stage and the
    // opcode arriving this cycle, so it behaves like an external flush
    assign w_flush_out = w_taken & ~bus.STALL;
    assign w_kill      = bus.FLUSH | w_flush_out;

    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            if (i == 0) begin : g_first
                // Stage 1 captures the decoded opcode when accepted
                always_ff @(posedge CLK) begin
                    if (RST) begin
                        r_valid[i] <= 1'b0;
                        r_ctrl[i]  <= '0;
                    end else if (w_kill) begin
                        r_valid[i] <= 1'b0;
                        r_ctrl[i]  <= '0;
                    end else if (!bus.STALL) begin
                        r_valid[i] <= w_accept;
                        r_ctrl[i]  <= w_accept ? w_dec : '0;
                    end
                end
            end else begin : g_shift
                // Later stages only shift the previous stage forward
                always_ff @(posedge CLK) begin
                    if (RST) begin
                        r_valid[i] <= 1'b0;
                        r_ctrl[i]  <= '0;
                    end else if (w_kill) begin
                        r_valid[i] <= 1'b0;
                        r_ctrl[i]  <= '0;
                    end else if (!bus.STALL) begin
                        r_valid[i] <= r_valid[i-1];
                        r_ctrl[i]  <= r_ctrl[i-1];
                    end
                end
            end
        end
    endgenerate

    // Output stage: controls are forced to zero when no instruction is held
    assign w_out_valid = r_valid[STAGES-1];
    assign w_out       = w_out_valid ? r_ctrl[STAGES-1] : '0;

    // Flag register: per-bit load under the output instruction's write mask
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_flags <= 4'b0000;
        end else if (w_out_valid && !bus.STALL) begin
            r_flags <= (r_flags & ~w_out.nzcvwrite) | (bus.NZCV_IN & w_out.nzcvwrite);
        end
    end

    // Branch resolution uses the flags as they stand before this cycle's update
    cp_cond_eval u_cond_eval (
        .i_cond  (w_out.cond),
        .i_flags (r_flags),
        .o_pass  (w_pass)
    );

    assign w_taken = w_out_valid & (w_out.r_branch | (w_out.c_branch & w_pass));

    assign bus.VALID_OUT = w_out_valid;
    assign bus.ALUOP     = w_out.aluop;
    assign bus.ALUSRC    = w_out.alusrc;
    assign bus.REGWRITE  = w_out.regwrite;
    assign bus.MEMRW     = w_out.memrw;
    assign bus.MEMTOREG  = w_out.memtoreg;
    assign bus.NZCVWRITE = w_out.nzcvwrite;
    assign bus.IMMSEL    = w_out.immsel;
    assign bus.BSEL      = w_out.bsel;
    assign bus.C_BRANCH  = w_out.c_branch;
    assign bus.R_BRANCH  = w_out.r_branch;
    assign bus.COND      = w_out.cond;
    assign bus.ILLEGAL   = w_out.illegal;
    assign bus.TAKEN     = w_taken;
    assign bus.FLUSH_OUT = w_flush_out;

endmodule
`default_nettype wire

// File: doc/pipe_cp_gen.md
PIPE_CP_GEN -- requirements
Module: pipe_cp_gen

Interface
REQ-001 SHALL take parameter OPW, default 10, opcode width (>=10; layout fixed in bits [9:0]).
REQ-002 SHALL take parameter STAGES, default 3, pipeline depth 1..4 from acceptance to VALID_OUT.
REQ-003 SHALL have one clock; reset is synchronous and active-high. Ports are CLK and RST.
REQ-004 Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- VALID_IN  in  1  OPCODE valid.
- OPCODE  in  OPW  instruction opcode.
- STALL  in  1  hold all stages.
- FLUSH  in  1  invalidate all stages.
- NZCV_IN  in  4  ALU flags for the output-stage instruction.
- READY  out  1  = ~STALL; opcode accepted when VALID_IN & READY.
- VALID_OUT  out  1  output stage holds a valid instruction.
- ALUOP  out  4  ALU operation.
- ALUSRC  out  1  ALU B source (1 = immediate).
- REGWRITE  out  1  register write enable.
- MEMRW  out  1  memory write.
- MEMTOREG  out  1  writeback from memory.
- NZCVWRITE  out  4  per-flag write mask, N,Z,C,V = bits 3..0.
- IMMSEL  out  4  one-hot immediate select.
- BSEL  out  1  PC-relative branch target.
- C_BRANCH  out  1  conditional branch.
- R_BRANCH  out  1  register branch.
- COND  out  4  condition code.
- TAKEN  out  1  branch resolved taken.
- FLUSH_OUT  out  1  younger stages being squashed.
- ILLEGAL  out  1  undefined opcode.

Function
REQ-005 Decode class = OPCODE[9:7]; S = OPCODE[4]; any nonzero bit above [9] SHALL force class 111.
REQ-006 Class 000 (ALU reg): ALUOP=OPCODE[3:0], ALUSRC=0, REGWRITE=1, IMMSEL=0001, NZCVWRITE = S ? 1111 : 0000.
REQ-007 Class 001 (ALU imm): as 000 but ALUSRC=1, IMMSEL=0010.
REQ-008 Class 010 (logical): as 000 but NZCVWRITE = S ? 1100 : 0000.
REQ-009 Class 011 (load): ALUOP=0100, ALUSRC=1, MEMTOREG=1, REGWRITE=1, IMMSEL=0100.
REQ-010 Class 100 (store): ALUOP=0100, ALUSRC=1, MEMRW=1, IMMSEL=0100.
REQ-011 Class 101 (B.cond): C_BRANCH=1, BSEL=1, IMMSEL=1000, COND=OPCODE[3:0].
REQ-012 Class 110 (BX): R_BRANCH=1, COND=1110.
REQ-013 Class 111: ILLEGAL=1; all other controls 0.
REQ-014 Unlisted fields SHALL be 0. All control outputs SHALL be 0 whenever VALID_OUT=0.
REQ-015 An accepted opcode SHALL reach VALID_OUT exactly STAGES cycles later, absent stall/flush. Decode happens in stage 1; later stages only shift.
REQ-016 STALL=1 SHALL freeze every stage and FLAGS. Outputs hold and remain visible.
REQ-017 FLUSH=1 SHALL clear every valid bit at the next edge. FLUSH overrides STALL.
REQ-018 Internal register FLAGS[3:0] SHALL load NZCV_IN bitwise under NZCVWRITE when VALID_OUT=1 and STALL=0.
REQ-019 TAKEN = VALID_OUT & (R_BRANCH | (C_BRANCH & pass(COND, FLAGS))). TAKEN uses FLAGS before that cycle's update.
REQ-020 pass() uses ARM semantics: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL=1, 1111=0.
REQ-021 When TAKEN=1 and STALL=0, FLUSH_OUT=1 and stages 1..STAGES-1 SHALL be invalidated at the next edge. The same-cycle acceptance SHALL be discarded.
REQ-022 For STALL=1, FLUSH_OUT=0.
REQ-023 With STAGES=1, FLUSH_OUT still asserts, but only the incoming opcode is discarded.

Reset
REQ-024 While RST=1 at a CLK edge: all valid bits 0, FLAGS=0000, all outputs 0, READY follows ~STALL.
REQ-025 RST mid-operation SHALL discard every in-flight instruction. RST SHALL override STALL and FLUSH.

Structure
REQ-026 Shared package cp_pkg SHALL hold class codes, COND codes, IMMSEL one-hot constants and the ALUOP add code (0100).
REQ-027 Condition evaluation SHALL be sub-module cp_cond_eval (COND and FLAGS in, pass out, combinational).
REQ-028 Stage registers SHALL be a generate loop over STAGES carrying a valid bit plus a packed control word.

Verification
REQ-029 STAGES=3, accept 0000011100 at cycle 0 -> VALID_OUT=1 at cycle 3, REGWRITE=1, ALUOP=1100, NZCVWRITE=1111, IMMSEL=0001.
REQ-030 Flag-setting ADD with NZCV_IN=0100 at output, then B.EQ (1010000000) -> TAKEN=1, FLUSH_OUT=1; the two younger opcodes never reach VALID_OUT.
REQ-031 Same sequence with NZCV_IN=0000 -> TAKEN=0, no flush; B.AL (1010001110) -> TAKEN=1 regardless of FLAGS.
REQ-032 STALL high 2 cycles with a load at output -> MEMTOREG=1 held 3 cycles, FLAGS unchanged, no opcode accepted.
REQ-033 FLUSH and STALL together -> next cycle VALID_OUT=0. RST with 3 in flight -> outputs 0, FLAGS=0000.
REQ-034 OPW=12, OPCODE=0x400 -> ILLEGAL=1, other controls 0. Opcode 1110000000 -> ILLEGAL=1, TAKEN=0.
